// File: rtl/fgp_fb_reader_pkg.sv
// Shared constants and types for the FGP framebuffer payload reader.
package fgp_fb_reader_pkg;

    localparam int FGP_DATA_LEN        = 768;
    localparam int FGP_DATA_LEN_COLORS = 512;
    localparam int COLOR_LEN           = 12;
    localparam int BYTE_LEN            = 8;

    localparam int OFFSET_W    = 8;
    localparam int BYTE_IDX_W  = $clog2(FGP_DATA_LEN);
    localparam int COLOR_IDX_W = $clog2(FGP_DATA_LEN_COLORS);
    localparam int PAIR_W      = COLOR_IDX_W - 1;
    localparam int ADDR_W      = OFFSET_W + COLOR_IDX_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Position of a byte inside its 3-byte / 2-color group.
    typedef enum logic [1:0] {
        PH_HI  = 2'd0,
        PH_MID = 2'd1,
        PH_LO  = 2'd2
    } phase_t;

    // Travels down the latency pipeline alongside each accepted request.
    typedef struct packed {
        logic   valid;
        phase_t phase;
        logic   last;
    } strobe_t;

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_HI:   return PH_MID;
            PH_MID:  return PH_LO;
            default: return PH_HI;
        endcase
    endfunction

endpackage

// File: rtl/fgp_fb_reader_delay.sv
// Fixed-depth shift-register delay line with synchronous clear.
module fgp_fb_reader_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift one stage per cycle; rst clears every stage at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fgp_fb_reader.sv
// Streams one framebuffer block (512 12-bit colors) as 768 packed bytes.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | no payload active; readclk ignored
// ST_STREAM | payload active; each readclk fetches/emits the next byte
//
// Output timing relies on LATENCY == RAM_READ_LATENCY + 1: ram_addr is
// registered one cycle after the request, so ram_data for a freshly issued
// color lines up exactly with the strobe leaving the delay line.
module fgp_fb_reader
    import fgp_fb_reader_pkg::*;
#(
    parameter int RAM_READ_LATENCY = 2,
    parameter int LATENCY          = RAM_READ_LATENCY + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OFFSET_W-1:0]  offset,
    input  logic                 readclk,
    output logic [ADDR_W-1:0]    ram_addr,
    input  logic [COLOR_LEN-1:0] ram_data,
    output logic                 outclk,
    output logic [BYTE_LEN-1:0]  out,
    output logic                 done
);

    state_t                state, state_nxt;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [PAIR_W-1:0]     pair;
    phase_t                phase;
    logic [OFFSET_W-1:0]   offset_buf;
    logic [3:0]            c0_lo;
    logic [7:0]            c1_lo;
    logic                  accept;
    logic                  last_byte;
    strobe_t               strobe_in, strobe_out;

    assign accept    = (state == ST_STREAM) && readclk && !start;
    assign last_byte = (byte_idx == BYTE_IDX_W'(FGP_DATA_LEN - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: start always (re)enters streaming; last byte ends it.
    always_comb begin
        state_nxt = state;
        if (start)                  state_nxt = ST_STREAM;
        else if (accept && last_byte) state_nxt = ST_IDLE;
    end

    // Byte position counters and the offset latched on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= '0;
            pair       <= '0;
            phase      <= PH_HI;
            offset_buf <= '0;
        end else if (start) begin
            byte_idx   <= '0;
            pair       <= '0;
            phase      <= PH_HI;
            offset_buf <= offset;
        end else if (accept) begin
            byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            phase    <= next_phase(phase);
            if (phase == PH_LO) pair <= pair + 1'b1;
        end
    end

    // Issue a color read for the first two bytes of each group; the third
    // byte is built entirely from the held second color.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr <= '0;
        end else if (accept && phase != PH_LO) begin
            ram_addr <= {offset_buf, pair, phase == PH_MID};
        end
    end

    always_comb begin
        strobe_in = '0;
        if (accept) begin
            strobe_in.valid = 1'b1;
            strobe_in.phase = phase;
            strobe_in.last  = last_byte;
        end
    end

    fgp_fb_reader_delay #(
        .WIDTH($bits(strobe_t)),
        .DEPTH(LATENCY)
    ) u_delay (
        .clk  (clk),
        .rst  (rst || start),
        .din  (strobe_in),
        .dout (strobe_out)
    );

    assign outclk = strobe_out.valid;
    assign done   = strobe_out.valid && strobe_out.last;

    // Keep only the color bits still needed by the following bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            c0_lo <= '0;
            c1_lo <= '0;
        end else if (outclk) begin
            if (strobe_out.phase == PH_HI)  c0_lo <= ram_data[3:0];
            if (strobe_out.phase == PH_MID) c1_lo <= ram_data[7:0];
        end
    end

    // Byte packing; out is forced to zero outside the strobe.
    always_comb begin
        out = '0;
        if (outclk) begin
            case (strobe_out.phase)
                PH_HI:   out = ram_data[11:4];
                PH_MID:  out = {c0_lo, ram_data[11:8]};
                default: out = c1_lo;
            endcase
        end
    end

endmodule

// File: tb/tb_fgp_fb_reader.sv
module tb_fgp_fb_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  offset;
    logic        readclk;
    logic [16:0] ram_addr;
    logic [11:0] ram_data;
    logic        outclk;
    logic [7:0]  out;
    logic        done;

    logic [11:0] mem [0:131071];
    logic [11:0] rd_d1;

    typedef struct {
        int         due;
        logic [7:0] b;
        logic       d;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          checks;
    int          errors;
    logic        stream_m;
    int          b_m;
    logic [7:0]  off_m;
    logic [16:0] exp_addr;

    fgp_fb_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .offset   (offset),
        .readclk  (readclk),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .outclk   (outclk),
        .out      (out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle registered RAM read.
    always @(posedge clk) begin
        rd_d1    <= mem[ram_addr];
        ram_data <= rd_d1;
    end

    task automatic check_outputs();
        exp_t       e;
        logic       exp_clk  = 1'b0;
        logic [7:0] exp_out  = 8'h00;
        logic       exp_done = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e        = sb.pop_front();
            exp_clk  = 1'b1;
            exp_out  = e.b;
            exp_done = e.d;
        end
        checks++;
        assert (outclk === exp_clk) else begin
            errors++;
            $error("FAIL outclk cyc=%0d observed=%b expected=%b", cyc, outclk, exp_clk);
        end
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL out cyc=%0d observed=%h expected=%h", cyc, out, exp_out);
        end
        checks++;
        assert (done === exp_done) else begin
            errors++;
            $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, done, exp_done);
        end
        checks++;
        assert (ram_addr === exp_addr) else begin
            errors++;
            $error("FAIL ram_addr cyc=%0d observed=%h expected=%h", cyc, ram_addr, exp_addr);
        end
    endtask

    // Drive one cycle of inputs, update the reference model, clock, check.
    task automatic step(input logic r, input logic s, input logic [7:0] off, input logic rc);
        int          p;
        int          k;
        logic [16:0] a0;
        logic [16:0] a1;
        logic [11:0] c0;
        logic [11:0] c1;
        exp_t        e;
        rst     = r;
        start   = s;
        offset  = off;
        readclk = rc;
        if (r) begin
            sb.delete();
            stream_m = 1'b0;
            b_m      = 0;
            off_m    = 8'h00;
            exp_addr = '0;
        end else if (s) begin
            sb.delete();
            stream_m = 1'b1;
            b_m      = 0;
            off_m    = off;
        end else if (rc && stream_m) begin
            p  = b_m / 3;
            k  = b_m % 3;
            a0 = {off_m, p[7:0], 1'b0};
            a1 = {off_m, p[7:0], 1'b1};
            c0 = mem[a0];
            c1 = mem[a1];
            e.due = cyc + 3;
            e.d   = (b_m == 767);
            case (k)
                0:       begin e.b = c0[11:4];           exp_addr = a0; end
                1:       begin e.b = {c0[3:0], c1[11:8]}; exp_addr = a1; end
                default: e.b = c1[7:0];
            endcase
            sb.push_back(e);
            b_m++;
            if (b_m == 768) stream_m = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = i[11:0];
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        stream_m = 1'b0;
        b_m      = 0;
        off_m    = 8'h00;
        exp_addr = '0;
        rst      = 1'b1;
        start    = 1'b0;
        offset   = 8'h00;
        readclk  = 1'b0;

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(2);

        // readclk without start: nothing happens
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(4);

        // full payload, back-to-back
        step(1'b0, 1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 768; i++) step(1'b0, 1'b0, 8'h55, 1'b1);
        idle(5);
        // readclk after done
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(4);

        // full payload, sparse
        step(1'b0, 1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 768; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            idle(3);
        end
        idle(4);

        // specific packing pattern
        mem[17'h00A00] = 12'hABC;
        mem[17'h00A01] = 12'hDEF;
        step(1'b0, 1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(5);

        // restart mid-payload, coinciding with a readclk
        step(1'b0, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h02, 1'b1);
        for (int i = 0; i < 768; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(5);

        // reset mid-payload, with start and readclk also asserted
        step(1'b0, 1'b1, 8'h07, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h09, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(6);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain observed=%0d pending expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
